jtag_tap_sampled: RTL and testbench
===================================

// Module: jtag_tap_sampled
// PURPOSE
//  IEEE 1149.1 TAP controller that consumes the JTAG pin stream from the socket/DPI pin driver
//  (tck/tms/tdi/trst) and returns tdo. All pins are oversampled in the clk_i domain; no logic runs on tck.
//  Provides IDCODE, BYPASS and one USER data register with parallel capture/update towards the debug unit.
// PARAMETERS
//  IR_WIDTH     5              instruction register width
//  DR_WIDTH     32             USER data register width
//  IDCODE_VAL   32'h1000_1C05  IDCODE value; bit0 must be 1
//  USER_INSTR   5'h10          IR opcode that selects the USER DR
// PORTS
//  clk_i             in   1         system clock; also the pin sampling clock
//  rst_ni            in   1         async active-low reset
//  tck_i             in   1         JTAG TCK, asynchronous to clk_i
//  tms_i             in   1         JTAG TMS
//  tdi_i             in   1         JTAG TDI
//  trst_ni           in   1         JTAG TRST, active-low
//  tdo_o             out  1         JTAG TDO
//  tdo_oe_o          out  1         high while in Shift-IR or Shift-DR
//  dr_capture_data_i in   DR_WIDTH  value loaded into the USER DR in Capture-DR
//  dr_update_o       out  1         1-cycle pulse on Update-DR while USER_INSTR is selected
//  dr_update_data_o  out  DR_WIDTH  USER shift register contents latched at Update-DR
// BEHAVIOUR
//  - Reset (rst_ni low): state=TEST_LOGIC_RESET, IR=IDCODE (5'h01), all shift registers=0,
//    tdo_o=0, tdo_oe_o=0, dr_update_o=0, dr_update_data_o=0, synchroniser flops=0.
//  - Synchronisers: tck/tms/tdi/trst_n each pass through 2 flops. Edge detection compares the
//    synchronised tck against a third flop.
//  - Latency: a tck_i rise becomes an FSM/shift event on the 3rd clk_i edge. tms/tdi are sampled
//    from their synchronised copies in that same cycle. The pin driver holds each pin state
//    >= 8 clk_i cycles, so tck high and low phases must each be >= 4 clk_i cycles.
//  - tck rising event:
//    - FSM advances on tms: the standard 16 states (TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR,
//      PA_DR, EX2_DR, UPD_DR and the IR equivalents) with IEEE transitions.
//    - In SH_IR/SH_DR, the selected register shifts right with tdi entering at the MSB.
//  - tck falling event: tdo_o <= LSB of the selected shift register (IR chain in SH_IR, DR chain
//    in SH_DR). tdo_o holds its value outside shift states.
//  - Capture-IR: IR shift register <= {0..,2'b01}.
//    Capture-DR:
//    - IDCODE: IDCODE_VAL.
//    - BYPASS: 1'b0.
//    - USER: dr_capture_data_i, sampled in that clk_i cycle.
//  - Update-IR: IR <= IR shift register. Update-DR with USER: dr_update_data_o <= shift register,
//    and dr_update_o pulses for exactly 1 clk_i cycle.
//  - Decode: 5'h01 selects IDCODE, USER_INSTR selects USER, all other codes (incl. all-ones)
//    select BYPASS (1-bit DR).
//  - Entering TLR (via tms or trst) forces IR=IDCODE.
//  - tdo_oe_o is registered and tracks state in {SH_IR, SH_DR}.
//  - trst_ni low (synchronised): FSM goes to TLR on the next clk_i edge, regardless of tck.
//    No update pulse is generated. A tck event in the same cycle is ignored (trst wins).
//  - Five tck rises with tms=1 reach TLR from any state.
//  - rst_ni asserted mid-shift: immediate reset values apply; no partial update is issued.
// CONFIGURATION
//  JTAG_TAP_TCK_FILTER_EN
//  - Defined: synchronised tck must hold a new level for 2 further consecutive clk_i cycles
//    before an edge is accepted, which rejects single-cycle glitches. Event latency becomes
//    5 clk_i edges.
//  - Undefined: no filter; latency 3 clk_i edges.
// TESTING
//  1 rst_ni pulse -> tdo_o=0, tdo_oe_o=0, state TLR, IR=5'h01; then 5 tck with tms=1 -> state stays TLR.
//  2 tms 0,1,0,0 then 32 shifts with tdi=0 -> tdo_o yields 32'h1000_1C05 LSB-first; tdo_oe_o=1
//    throughout the shift.
//  3 Shift-IR with tdi=0 -> first 5 tdo_o bits = 1,0,0,0,0. Then load IR=5'h1F and shift
//    0xA5 -> tdo_o is the input delayed by one bit, first bit 0.
//  4 IR=5'h10, dr_capture_data_i=32'hDEAD_BEEF, shift in 32'h1234_5678, Update-DR
//    -> tdo_o = DEADBEEF LSB-first; single dr_update_o pulse; dr_update_data_o=32'h1234_5678.
//  5 trst_ni low for 4 clk_i mid Shift-DR -> TLR within 3 clk_i, IR=5'h01, tdo_oe_o=0,
//    no dr_update_o.
//  6 With JTAG_TAP_TCK_FILTER_EN, a 1-cycle tck glitch -> no state change; a clean edge
//    -> event at the 5th clk_i edge.

Source files
------------

// File: rtl/jtag_tap_sampled.sv
// IEEE 1149.1 TAP with every JTAG pin oversampled in clk_i; IDCODE, BYPASS and one USER DR.
// Optional build macro JTAG_TAP_TCK_FILTER_EN adds a 2-cycle stability filter on tck.
module jtag_tap_sampled #(
  parameter int                  IR_WIDTH   = 5,
  parameter int                  DR_WIDTH   = 32,
  parameter logic [31:0]         IDCODE_VAL = 32'h1000_1C05,
  parameter logic [IR_WIDTH-1:0] USER_INSTR = 5'h10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                tck_i,
  input  logic                tms_i,
  input  logic                tdi_i,
  input  logic                trst_ni,
  output logic                tdo_o,
  output logic                tdo_oe_o,
  input  logic [DR_WIDTH-1:0] dr_capture_data_i,
  output logic                dr_update_o,
  output logic [DR_WIDTH-1:0] dr_update_data_o
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } state_e;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);

  logic [1:0] tck_s_q, tms_s_q, tdi_s_q, trst_s_q;
  logic       tck_lvl_q, tck_lvl_d;
  logic       tck_acc, tck_rise, tck_fall;

  state_e                state_q, state_d;
  logic [IR_WIDTH-1:0]   ir_q, ir_d, ir_sh_q, ir_sh_d;
  logic [31:0]           id_sh_q, id_sh_d;
  logic [DR_WIDTH-1:0]   dr_sh_q, dr_sh_d, upd_data_q, upd_data_d;
  logic                  byp_q, byp_d, tdo_q, tdo_d, oe_q, oe_d, upd_q, upd_d;
  logic                  tms, tdi, sel_idcode, sel_user;

  assign tms = tms_s_q[1];
  assign tdi = tdi_s_q[1];

`ifdef JTAG_TAP_TCK_FILTER_EN
  // A new tck level must persist for two more cycles before the edge is accepted.
  logic [1:0] flt_cnt_q, flt_cnt_d;
  always_comb begin
    tck_acc   = (tck_s_q[1] != tck_lvl_q) && (flt_cnt_q == 2'd2);
    flt_cnt_d = 2'd0;
    if ((tck_s_q[1] != tck_lvl_q) && !tck_acc) flt_cnt_d = flt_cnt_q + 2'd1;
    tck_lvl_d = tck_acc ? tck_s_q[1] : tck_lvl_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) flt_cnt_q <= 2'd0;
    else         flt_cnt_q <= flt_cnt_d;
  end
`else
  always_comb begin
    tck_acc   = tck_s_q[1] != tck_lvl_q;
    tck_lvl_d = tck_s_q[1];
  end
`endif

  assign tck_rise = tck_acc & tck_s_q[1];
  assign tck_fall = tck_acc & ~tck_s_q[1];

  assign sel_idcode = (ir_q == IR_IDCODE);
  assign sel_user   = (ir_q == USER_INSTR);

  function automatic state_e next_state(input state_e s, input logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PA_DR;
      PA_DR:   return m ? EX2_DR : PA_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PA_IR;
      PA_IR:   return m ? EX2_IR : PA_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      UPD_IR:  return m ? SEL_DR : RTI;
      default: return TLR;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_sh_d    = ir_sh_q;
    id_sh_d    = id_sh_q;
    dr_sh_d    = dr_sh_q;
    byp_d      = byp_q;
    tdo_d      = tdo_q;
    upd_d      = 1'b0;
    upd_data_d = upd_data_q;
    if (!trst_s_q[1]) begin
      state_d = TLR;   // trst overrides any tck event in the same cycle
    end else begin
      if (tck_rise) begin
        case (state_q)
          CAP_IR: ir_sh_d = IR_IDCODE;
          SH_IR:  ir_sh_d = {tdi, ir_sh_q[IR_WIDTH-1:1]};
          CAP_DR: begin
            if (sel_idcode)    id_sh_d = IDCODE_VAL;
            else if (sel_user) dr_sh_d = dr_capture_data_i;
            else               byp_d   = 1'b0;
          end
          SH_DR: begin
            if (sel_idcode)    id_sh_d = {tdi, id_sh_q[31:1]};
            else if (sel_user) dr_sh_d = {tdi, dr_sh_q[DR_WIDTH-1:1]};
            else               byp_d   = tdi;
          end
          default: ;
        endcase
        state_d = next_state(state_q, tms);
      end
      if (tck_fall) begin
        case (state_q)
          SH_IR: tdo_d = ir_sh_q[0];
          SH_DR: tdo_d = sel_idcode ? id_sh_q[0] : (sel_user ? dr_sh_q[0] : byp_q);
          UPD_IR: ir_d = ir_sh_q;
          UPD_DR: begin
            if (sel_user) begin
              upd_d      = 1'b1;
              upd_data_d = dr_sh_q;
            end
          end
          default: ;
        endcase
      end
    end
    if (state_d == TLR) ir_d = IR_IDCODE;
    oe_d = (state_d == SH_IR) || (state_d == SH_DR);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tck_s_q    <= '0;
      tms_s_q    <= '0;
      tdi_s_q    <= '0;
      trst_s_q   <= '0;
      tck_lvl_q  <= 1'b0;
      state_q    <= TLR;
      ir_q       <= IR_IDCODE;
      ir_sh_q    <= '0;
      id_sh_q    <= '0;
      dr_sh_q    <= '0;
      byp_q      <= 1'b0;
      tdo_q      <= 1'b0;
      oe_q       <= 1'b0;
      upd_q      <= 1'b0;
      upd_data_q <= '0;
    end else begin
      tck_s_q    <= {tck_s_q[0], tck_i};
      tms_s_q    <= {tms_s_q[0], tms_i};
      tdi_s_q    <= {tdi_s_q[0], tdi_i};
      trst_s_q   <= {trst_s_q[0], trst_ni};
      tck_lvl_q  <= tck_lvl_d;
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_sh_q    <= ir_sh_d;
      id_sh_q    <= id_sh_d;
      dr_sh_q    <= dr_sh_d;
      byp_q      <= byp_d;
      tdo_q      <= tdo_d;
      oe_q       <= oe_d;
      upd_q      <= upd_d;
      upd_data_q <= upd_data_d;
    end
  end

  assign tdo_o            = tdo_q;
  assign tdo_oe_o         = oe_q;
  assign dr_update_o      = upd_q;
  assign dr_update_data_o = upd_data_q;

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Directed bench for jtag_tap_sampled: drives slow tck pulses and checks tdo, tdo_oe and DR updates.
module tb_jtag_tap_sampled;
  logic        clk = 1'b0;
  logic        rst_n, tck, tms, tdi, trst_n, tdo, tdo_oe, dr_upd;
  logic [31:0] cap_data, upd_data;
  int          n_cmp = 0, n_bad = 0, upd_cnt = 0;
  logic [63:0] dout;
  logic        oe_all, t, o;

  always #5 clk = ~clk;

  jtag_tap_sampled dut (
    .clk_i(clk), .rst_ni(rst_n), .tck_i(tck), .tms_i(tms), .tdi_i(tdi), .trst_ni(trst_n),
    .tdo_o(tdo), .tdo_oe_o(tdo_oe), .dr_capture_data_i(cap_data),
    .dr_update_o(dr_upd), .dr_update_data_o(upd_data)
  );

  always @(negedge clk) if (dr_upd) upd_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tck_pulse(input logic m, input logic d, output logic tdo_s, output logic oe_s);
    @(negedge clk);
    tms = m;
    tdi = d;
    repeat (4) @(negedge clk);
    tck = 1'b1;
    repeat (8) @(negedge clk);
    tck = 1'b0;
    repeat (8) @(negedge clk);
    tdo_s = tdo;
    oe_s  = tdo_oe;
  endtask

  // From RTI: scan n bits through IR or DR, update, return to RTI. dq holds tdo bits LSB-first.
  task automatic scan(input logic is_ir, input int n, input logic [63:0] din,
                      output logic [63:0] dq, output logic oe_ok);
    logic b, e;
    dq    = '0;
    oe_ok = 1'b1;
    tck_pulse(1'b1, 1'b0, b, e);
    if (is_ir) tck_pulse(1'b1, 1'b0, b, e);
    tck_pulse(1'b0, 1'b0, b, e);
    tck_pulse(1'b0, 1'b0, b, e);
    dq[0] = b;
    oe_ok &= e;
    for (int i = 0; i < n; i++) begin
      tck_pulse(i == n - 1, din[i], b, e);
      if (i < n - 1) begin
        dq[i+1] = b;
        oe_ok &= e;
      end
    end
    tck_pulse(1'b1, 1'b0, b, e);
    tck_pulse(1'b0, 1'b0, b, e);
  endtask

  initial begin
    rst_n = 1'b0; tck = 1'b0; tms = 1'b1; tdi = 1'b0; trst_n = 1'b1; cap_data = '0;
    repeat (4) @(negedge clk);
    chk("rst_tdo", 64'(tdo), 64'd0);
    chk("rst_oe", 64'(tdo_oe), 64'd0);
    chk("rst_upd_data", 64'(upd_data), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // TLR is sticky under tms=1, then IDCODE is the default instruction
    for (int i = 0; i < 5; i++) tck_pulse(1'b1, 1'b0, t, o);
    chk("tlr_oe", 64'(o), 64'd0);
    tck_pulse(1'b0, 1'b0, t, o);
    scan(1'b0, 32, 64'd0, dout, oe_all);
    chk("idcode", dout, 64'h1000_1C05);
    chk("idcode_oe", 64'(oe_all), 64'd1);

    scan(1'b1, 5, 64'h00, dout, oe_all);
    chk("ir_capture", dout, 64'h01);
    chk("ir_oe", 64'(oe_all), 64'd1);
    scan(1'b1, 5, 64'h1F, dout, oe_all);
    chk("ir_capture2", dout, 64'h01);
    scan(1'b0, 8, 64'hA5, dout, oe_all);
    chk("bypass", dout, 64'h4A);

    scan(1'b1, 5, 64'h10, dout, oe_all);
    cap_data = 32'hDEAD_BEEF;
    upd_cnt  = 0;
    scan(1'b0, 32, 64'h1234_5678, dout, oe_all);
    chk("user_capture", dout, 64'hDEAD_BEEF);
    chk("user_upd_cnt", 64'(upd_cnt), 64'd1);
    chk("user_upd_data", 64'(upd_data), 64'h1234_5678);

    // Into CAP_DR, then time the rising-edge event that moves to SH_DR
    tck_pulse(1'b1, 1'b0, t, o);
    tck_pulse(1'b0, 1'b0, t, o);
`ifdef JTAG_TAP_TCK_FILTER_EN
    @(negedge clk);
    tms = 1'b0;
    repeat (4) @(negedge clk);
    tck = 1'b1;
    @(negedge clk);
    tck = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_ignored", 64'(tdo_oe), 64'd0);
    tck = 1'b1;
    repeat (4) @(negedge clk);
    chk("lat_before", 64'(tdo_oe), 64'd0);
    @(negedge clk);
    chk("lat_at", 64'(tdo_oe), 64'd1);
`else
    @(negedge clk);
    tms = 1'b0;
    repeat (4) @(negedge clk);
    tck = 1'b1;
    repeat (2) @(negedge clk);
    chk("lat_before", 64'(tdo_oe), 64'd0);
    @(negedge clk);
    chk("lat_at", 64'(tdo_oe), 64'd1);
`endif
    repeat (8) @(negedge clk);
    tck = 1'b0;
    repeat (8) @(negedge clk);

    upd_cnt = 0;
    trst_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk("trst_oe", 64'(tdo_oe), 64'd0);
    @(negedge clk);
    trst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("trst_no_upd", 64'(upd_cnt), 64'd0);
    tck_pulse(1'b0, 1'b0, t, o);
    scan(1'b0, 32, 64'd0, dout, oe_all);
    chk("trst_idcode", dout, 64'h1000_1C05);

    // rst_ni in the middle of a USER shift
    scan(1'b1, 5, 64'h10, dout, oe_all);
    tck_pulse(1'b1, 1'b0, t, o);
    tck_pulse(1'b0, 1'b0, t, o);
    tck_pulse(1'b0, 1'b1, t, o);
    tck_pulse(1'b0, 1'b1, t, o);
    chk("mid_oe", 64'(o), 64'd1);
    upd_cnt = 0;
    rst_n   = 1'b0;
    #1;
    chk("rst_mid_oe", 64'(tdo_oe), 64'd0);
    chk("rst_mid_upd_data", 64'(upd_data), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_mid_no_upd", 64'(upd_cnt), 64'd0);
    tck_pulse(1'b0, 1'b0, t, o);
    scan(1'b0, 32, 64'd0, dout, oe_all);
    chk("rst_idcode", dout, 64'h1000_1C05);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
